// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, one bit per cycle.
// Define MULDIV_EARLY_TERM_EN to let multiplies finish once the remaining multiplier bits are zero.
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, step, prod, prod_s;
    logic [WIDTH-1:0]   m, a_raw, hi, lo, abs_a, abs_b, q_s, r_s, res_hi, res_lo;
    logic [WIDTH:0]     sum, rem_sh, diff;
    logic [1:0]         op_r;
    logic               neg_q, neg_r, div0, done_r, sign_a, sign_b, ge, early, is_div;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        if (state == IDLE)
            state_nx = (start && !flush) ? RUN : IDLE;
        else if (state == RUN)
            state_nx = flush ? IDLE : (early || cnt == CNT_W'(1)) ? FIN : RUN;
    end

    always_comb begin
        busy   = state != IDLE;
        done   = done_r;
        hi_out = hi;
        lo_out = lo;
    end

    // Operand magnitudes and result signs, captured at issue.
    always_comb begin
        sign_a = ~op[0] & opA[WIDTH-1];
        sign_b = ~op[0] & opB[WIDTH-1];
        abs_a  = sign_a ? -opA : opA;
        abs_b  = sign_b ? -opB : opB;
    end

    // Upper half of acc is the partial product or remainder; lower half the multiplier or quotient.
    always_comb begin
        is_div = op_r[1];
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m};
        rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff   = rem_sh - {1'b0, m};
        ge     = rem_sh >= {1'b0, m};
        step   = is_div ? {ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0], acc[WIDTH-2:0], ge}
               : acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
`ifdef MULDIV_EARLY_TERM_EN
        early  = !is_div && ((acc[WIDTH-1:0] & ~({WIDTH{1'b1}} << cnt)) == '0);
        prod   = acc >> cnt;
`else
        early  = 1'b0;
        prod   = acc;
`endif
        prod_s = neg_q ? -prod : prod;
        q_s    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_s    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_hi = is_div ? (div0 ? a_raw : r_s) : prod_s[2*WIDTH-1:WIDTH];
        res_lo = is_div ? (div0 ? {WIDTH{1'b1}} : q_s) : prod_s[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            m      <= '0;
            a_raw  <= '0;
            hi     <= '0;
            lo     <= '0;
            op_r   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state == IDLE) begin
                if (hi_we) hi <= wr_data;
                if (lo_we) lo <= wr_data;
                if (start && !flush) begin
                    acc   <= {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
                    m     <= op[1] ? abs_b : abs_a;
                    a_raw <= opA;
                    op_r  <= op;
                    neg_q <= sign_a ^ sign_b;
                    neg_r <= sign_a;
                    div0  <= opB == '0;
                    cnt   <= CNT_W'(WIDTH);
                end
            end else if (state == RUN) begin
                if (!flush && !early) begin
                    acc <= step;
                    cnt <= cnt - CNT_W'(1);
                end
            end else if (state == FIN && !flush) begin
                hi     <= res_hi;
                lo     <= res_lo;
                done_r <= 1'b1;
            end
        end
    end
endmodule
